// File: rtl/dual_pkg.sv
// Shared definitions for the dual-issue writeback stage: default widths and the
// per-slot writeback bundle. Optional feature macro used by this slice: RF_BYPASS_EN.
package dual_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 8;
  localparam int DEF_NREG   = 32;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_PC_W-1:0]   pc;
  } wb_port_t;

  // A slot only touches the array when it retires, writes, and targets a real register.
  function automatic logic wb_effective(input wb_port_t p);
    return p.valid & p.we & (p.addr != '0);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One decode read port: r0 forced to zero and, when RF_BYPASS_EN is defined,
// same-cycle writeback bypass with slot 1 taking priority over slot 0.
module rf_read_port
  import dual_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [REG_ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0]     i_arr_data,
`ifdef RF_BYPASS_EN
  input  logic                  i_byp0_en,
  input  logic [REG_ADDR_W-1:0] i_byp0_addr,
  input  logic [DATA_W-1:0]     i_byp0_data,
  input  logic                  i_byp1_en,
  input  logic [REG_ADDR_W-1:0] i_byp1_addr,
  input  logic [DATA_W-1:0]     i_byp1_data,
`endif
  output logic [DATA_W-1:0]     o_rdata
);

  always_comb begin
    o_rdata = i_arr_data;
    if (i_raddr == '0) begin
      o_rdata = '0;
    end
`ifdef RF_BYPASS_EN
    // Enables already exclude r0, so the zero check above still dominates.
    else if (i_byp1_en && (i_byp1_addr == i_raddr)) begin
      o_rdata = i_byp1_data;
    end else if (i_byp0_en && (i_byp0_addr == i_raddr)) begin
      o_rdata = i_byp0_data;
    end
`endif
  end

endmodule

// File: rtl/wb_dual_regfile.sv
// Dual-slot writeback commit point: register array, retirement counter and last PC.
// Define RF_BYPASS_EN for write-before-read forwarding on the four read ports.
module wb_dual_regfile
  import dual_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int PC_W   = DEF_PC_W,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid0,
  input  logic                  valid1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [REG_ADDR_W-1:0] waddr0,
  input  logic [REG_ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [PC_W-1:0]       wpc0,
  input  logic [PC_W-1:0]       wpc1,
  input  logic [REG_ADDR_W-1:0] raddr0,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  input  logic [REG_ADDR_W-1:0] raddr3,
  output logic [DATA_W-1:0]     rdata0,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  output logic [DATA_W-1:0]     rdata3,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [PC_W-1:0]       last_pc,
  output logic                  collision
);

  // Slot bundles are sized by the package defaults; DATA_W/PC_W must match them.
  wb_port_t w_slot0, w_slot1;
  logic     w_eff0, w_eff1, w_same_dst;

  logic [DATA_W-1:0]     r_regs [NREG];
  logic [CNT_W-1:0]      r_cnt;
  logic [PC_W-1:0]       r_last_pc;
  logic                  r_collision;
  logic [REG_ADDR_W-1:0] w_raddr [4];
  logic [DATA_W-1:0]     w_rdata [4];

  assign w_slot0 = '{valid: valid0, we: we0, addr: waddr0, data: wdata0, pc: wpc0};
  assign w_slot1 = '{valid: valid1, we: we1, addr: waddr1, data: wdata1, pc: wpc1};

  assign w_eff0     = wb_effective(w_slot0) && (int'(w_slot0.addr) < NREG);
  assign w_eff1     = wb_effective(w_slot1) && (int'(w_slot1.addr) < NREG);
  assign w_same_dst = w_eff0 && w_eff1 && (w_slot0.addr == w_slot1.addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_cnt       <= '0;
      r_last_pc   <= '0;
      r_collision <= 1'b0;
    end else begin
      // Slot 1 is younger in program order, so it owns a shared destination.
      if (w_eff0 && !w_same_dst) r_regs[w_slot0.addr] <= w_slot0.data;
      if (w_eff1)                r_regs[w_slot1.addr] <= w_slot1.data;
      r_cnt       <= r_cnt + CNT_W'(w_slot0.valid) + CNT_W'(w_slot1.valid);
      r_collision <= w_same_dst;
      if (w_slot1.valid)      r_last_pc <= w_slot1.pc;
      else if (w_slot0.valid) r_last_pc <= w_slot0.pc;
    end
  end

  assign w_raddr[0] = raddr0;
  assign w_raddr[1] = raddr1;
  assign w_raddr[2] = raddr2;
  assign w_raddr[3] = raddr3;

  for (genvar g = 0; g < 4; g++) begin : g_rport
    rf_read_port #(.DATA_W(DATA_W)) u_rport (
      .i_raddr     (w_raddr[g]),
      .i_arr_data  (r_regs[w_raddr[g]]),
`ifdef RF_BYPASS_EN
      .i_byp0_en   (w_eff0),
      .i_byp0_addr (w_slot0.addr),
      .i_byp0_data (w_slot0.data),
      .i_byp1_en   (w_eff1),
      .i_byp1_addr (w_slot1.addr),
      .i_byp1_data (w_slot1.data),
`endif
      .o_rdata     (w_rdata[g])
    );
  end

  assign rdata0      = w_rdata[0];
  assign rdata1      = w_rdata[1];
  assign rdata2      = w_rdata[2];
  assign rdata3      = w_rdata[3];
  assign retired_cnt = r_cnt;
  assign last_pc     = r_last_pc;
  assign collision   = r_collision;

endmodule

// File: tb/tb_wb_dual_regfile.sv
// Directed table-driven bench for wb_dual_regfile with a 4-bit retire counter so
// wraparound is reachable; expectations follow RF_BYPASS_EN when it is defined.
module tb_wb_dual_regfile;

  localparam int CW = 4;

  logic        clk, reset;
  logic        valid0, valid1, we0, we1;
  logic [4:0]  waddr0, waddr1, raddr0, raddr1, raddr2, raddr3;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, rdata2, rdata3;
  logic [7:0]  wpc0, wpc1, last_pc;
  logic [CW-1:0] retired_cnt;
  logic        collision;

  int n_checks = 0;
  int n_fail   = 0;

  wb_dual_regfile #(.DATA_W(32), .NREG(32), .PC_W(8), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .valid0(valid0), .valid1(valid1), .we0(we0), .we1(we1),
    .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
    .wpc0(wpc0), .wpc1(wpc1),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .retired_cnt(retired_cnt), .last_pc(last_pc), .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v0; logic we0; logic [4:0] a0; logic [31:0] d0; logic [7:0] pc0;
    logic v1; logic we1; logic [4:0] a1; logic [31:0] d1; logic [7:0] pc1;
    logic [3:0][4:0]  ra;
    logic [3:0][31:0] erd;
    logic [CW-1:0] ecnt; logic [7:0] epc; logic ecoll;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid0 = 0; valid1 = 0; we0 = 0; we1 = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; wpc0 = 0; wpc1 = 0;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".rdata0"}, 64'(rdata0), 64'(v.erd[0]));
    check({tag, ".rdata1"}, 64'(rdata1), 64'(v.erd[1]));
    check({tag, ".rdata2"}, 64'(rdata2), 64'(v.erd[2]));
    check({tag, ".rdata3"}, 64'(rdata3), 64'(v.erd[3]));
    check({tag, ".retired_cnt"}, 64'(retired_cnt), 64'(v.ecnt));
    check({tag, ".last_pc"}, 64'(last_pc), 64'(v.epc));
    check({tag, ".collision"}, 64'(collision), 64'(v.ecoll));
  endtask

  initial begin
    // Expected values are the state visible one edge after each vector, read with writes idle.
    vecs[0]  = '{1'b1,1'b1,5'd5,32'h1234,8'h10, 1'b0,1'b0,5'd0,32'h0,8'h00,
                 {5'd0,5'd0,5'd0,5'd5}, {32'h0,32'h0,32'h0,32'h1234}, 4'd1, 8'h10, 1'b0};
    vecs[1]  = '{1'b1,1'b1,5'd3,32'hAAAA,8'h11, 1'b1,1'b1,5'd7,32'h5555,8'h12,
                 {5'd0,5'd5,5'd7,5'd3}, {32'h0,32'h1234,32'h5555,32'hAAAA}, 4'd3, 8'h12, 1'b0};
    vecs[2]  = '{1'b1,1'b1,5'd9,32'h1111,8'h13, 1'b1,1'b1,5'd9,32'h2222,8'h14,
                 {5'd0,5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h0,32'h2222}, 4'd5, 8'h14, 1'b1};
    vecs[3]  = '{1'b0,1'b0,5'd0,32'h0,8'h00, 1'b0,1'b0,5'd0,32'h0,8'h00,
                 {5'd5,5'd7,5'd3,5'd9}, {32'h1234,32'h5555,32'hAAAA,32'h2222}, 4'd5, 8'h14, 1'b0};
    vecs[4]  = '{1'b1,1'b1,5'd0,32'hFFFF,8'h20, 1'b0,1'b1,5'd4,32'hDEAD,8'h21,
                 {5'd0,5'd9,5'd4,5'd0}, {32'h0,32'h2222,32'h0,32'h0}, 4'd6, 8'h20, 1'b0};
    vecs[5]  = '{1'b1,1'b0,5'd3,32'h0,8'h22, 1'b1,1'b0,5'd7,32'h0,8'h23,
                 {5'd0,5'd0,5'd7,5'd3}, {32'h0,32'h0,32'h5555,32'hAAAA}, 4'd8, 8'h23, 1'b0};
    vecs[6]  = '{1'b1,1'b1,5'd10,32'h1,8'h24, 1'b1,1'b1,5'd11,32'h2,8'h25,
                 {5'd0,5'd0,5'd11,5'd10}, {32'h0,32'h0,32'h2,32'h1}, 4'd10, 8'h25, 1'b0};
    vecs[7]  = '{1'b1,1'b1,5'd12,32'h3,8'h26, 1'b1,1'b1,5'd13,32'h4,8'h27,
                 {5'd0,5'd0,5'd13,5'd12}, {32'h0,32'h0,32'h4,32'h3}, 4'd12, 8'h27, 1'b0};
    vecs[8]  = '{1'b1,1'b0,5'd0,32'h0,8'h28, 1'b1,1'b0,5'd0,32'h0,8'h29,
                 {5'd0,5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0,32'h0}, 4'd14, 8'h29, 1'b0};
    vecs[9]  = '{1'b1,1'b0,5'd0,32'h0,8'h2A, 1'b0,1'b0,5'd0,32'h0,8'h99,
                 {5'd0,5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0,32'h0}, 4'd15, 8'h2A, 1'b0};
    vecs[10] = '{1'b1,1'b1,5'd14,32'h5,8'h2B, 1'b1,1'b1,5'd15,32'h6,8'h2C,
                 {5'd13,5'd12,5'd11,5'd10}, {32'h4,32'h3,32'h2,32'h1}, 4'd1, 8'h2C, 1'b0};
    vecs[11] = '{1'b0,1'b1,5'd14,32'h777,8'h55, 1'b1,1'b1,5'd14,32'h888,8'h2D,
                 {5'd0,5'd0,5'd15,5'd14}, {32'h0,32'h0,32'h6,32'h888}, 4'd2, 8'h2D, 1'b0};
    vecs[12] = '{1'b1,1'b1,5'd0,32'hFF,8'h2E, 1'b1,1'b1,5'd0,32'hEE,8'h2F,
                 {5'd0,5'd0,5'd14,5'd0}, {32'h0,32'h0,32'h888,32'h0}, 4'd4, 8'h2F, 1'b0};

    idle_inputs();
    raddr0 = 0; raddr1 = 0; raddr2 = 0; raddr3 = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset.rdata0", 64'(rdata0), 64'h0);
    check("reset.retired_cnt", 64'(retired_cnt), 64'h0);
    check("reset.last_pc", 64'(last_pc), 64'h0);
    check("reset.collision", 64'(collision), 64'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      valid0 = vecs[i].v0; we0 = vecs[i].we0; waddr0 = vecs[i].a0; wdata0 = vecs[i].d0; wpc0 = vecs[i].pc0;
      valid1 = vecs[i].v1; we1 = vecs[i].we1; waddr1 = vecs[i].a1; wdata1 = vecs[i].d1; wpc1 = vecs[i].pc1;
      raddr0 = vecs[i].ra[0]; raddr1 = vecs[i].ra[1]; raddr2 = vecs[i].ra[2]; raddr3 = vecs[i].ra[3];
      @(posedge clk);
      #1 idle_inputs();
      #1 check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Same-cycle read of a register being written: bypass vs. pre-edge value.
    @(negedge clk);
    valid0 = 1; we0 = 1; waddr0 = 5'd6; wdata0 = 32'hBEEF; wpc0 = 8'h30;
    valid1 = 1; we1 = 1; waddr1 = 5'd0; wdata1 = 32'h1357; wpc1 = 8'h31;
    raddr2 = 5'd6; raddr3 = 5'd0;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass.same_cycle", 64'(rdata2), 64'hBEEF);
`else
    check("nobypass.same_cycle", 64'(rdata2), 64'h0);
`endif
    check("bypass.r0_never", 64'(rdata3), 64'h0);
    @(posedge clk);
    #1 idle_inputs();
    #1 check("bypass.next_cycle", 64'(rdata2), 64'hBEEF);

    // Collision pulse, then asynchronous reset mid-cycle with a write pending.
    @(negedge clk);
    valid0 = 1; we0 = 1; waddr0 = 5'd20; wdata0 = 32'hA; wpc0 = 8'h40;
    valid1 = 1; we1 = 1; waddr1 = 5'd20; wdata1 = 32'hB; wpc1 = 8'h41;
    @(posedge clk);
    #1 idle_inputs();
    #1 check("prereset.collision", 64'(collision), 64'h1);
    raddr0 = 5'd5; raddr1 = 5'd14; raddr2 = 5'd8; raddr3 = 5'd20;
    @(negedge clk);
    valid0 = 1; we0 = 1; waddr0 = 5'd8; wdata0 = 32'h99; wpc0 = 8'h50;
    #2 reset = 1'b0;
    #1;
    check("midreset.rdata0", 64'(rdata0), 64'h0);
    check("midreset.rdata1", 64'(rdata1), 64'h0);
    check("midreset.rdata3", 64'(rdata3), 64'h0);
    check("midreset.retired_cnt", 64'(retired_cnt), 64'h0);
    check("midreset.last_pc", 64'(last_pc), 64'h0);
    check("midreset.collision", 64'(collision), 64'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("postreset.r8_lost", 64'(rdata2), 64'h0);
    check("postreset.retired_cnt", 64'(retired_cnt), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_dual_regfile.md
# wb_dual_regfile

Architectural register file and writeback commit point of the dual-issue core. It consumes the MEM/WB outputs of both issue slots (inst0 and inst1): it performs up to two register writes per cycle with deterministic collision resolution, serves four combinational read ports to decode, and keeps retirement state (retired-instruction count, last committed PC+1) for debug.

## Interface
- DATA_W, 32: register width
- NREG, 32: register count; r0 is hardwired zero
- PC_W, 8: width of pcPlus1 values
- CNT_W, 32: retired-instruction counter width
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low; clock clk
- valid0 / valid1  in  1  slot 0 / slot 1 instruction retires this cycle
- we0 / we1  in  1  slot writes a register (RegWriteEn_WB)
- waddr0 / waddr1  in  5  destination register (dest_reg_WB)
- wdata0 / wdata1  in  DATA_W  writeback data (writeData_WB)
- wpc0 / wpc1  in  PC_W  pcPlus1_WB of each slot
- raddr0..raddr3  in  5  read addresses (inst0 rs/rt, inst1 rs/rt)
- rdata0..rdata3  out  DATA_W  read data, combinational
- retired_cnt  out  CNT_W  total retired instructions
- last_pc  out  PC_W  pcPlus1 of the youngest retired instruction
- collision  out  1  registered flag: previous cycle had a same-register dual write

## Operation
- Effective write k: valid_k & we_k & (waddr_k != 0). Writes to r0 are discarded; r0 always reads 0.
- Both effective, different addresses: both registers written in the same edge.
- Both effective, same address: slot 1 (younger in program order) wins; wdata0 dropped; collision <= 1 for one cycle. Otherwise collision <= 0.
- retired_cnt <= retired_cnt + valid0 + valid1 (increment 0, 1, or 2); wraps modulo 2^CNT_W, no saturation.
- last_pc <= wpc1 if valid1; else wpc0 if valid0; else hold.
- valid_k = 0 with we_k = 1 writes nothing (squashed slot).
- Reads: rdata_i = 0 if raddr_i == 0, else array contents, subject to bypass (see Configuration).
- Reset (async, any time, including mid-cycle with writes pending): all NREG registers, retired_cnt, last_pc, collision cleared to 0; writes presented in that cycle are lost. rdata reflect cleared array immediately.

## Timing
- Write latency: data presented in cycle N visible in array after posedge ending cycle N.
- Read latency: zero (combinational from raddr and array).
- retired_cnt, last_pc, collision update at the same edge as the writes they describe.
- No handshake, no backpressure: every presented retirement is accepted every cycle.

## Configuration
- RF_BYPASS_EN defined: rdata_i returns the same-cycle effective write data when raddr_i matches an effective waddr (slot 1 priority over slot 0, r0 never bypassed), giving write-before-read semantics; removes the WB->ID hazard.
- RF_BYPASS_EN undefined: rdata_i returns array contents only (pre-edge value); the hazard unit must stall or forward for the WB->ID distance.

## Structure
- Shared package dual_pkg: DATA_W, REG_ADDR_W (5), PC_W, NREG constants and the writeback port struct {valid, we, addr, data, pc}.
- One sub-module rf_read_port: the per-port zero-check plus bypass mux, instantiated four times; array, counter, and last_pc live in the top.

## Test plan
- Reset low mid-run with r5=0x1234 -> all rdata 0, retired_cnt 0, last_pc 0, collision 0 immediately.
- valid0/we0 r3=0xAAAA, valid1/we1 r7=0x5555, same cycle -> next cycle r3=0xAAAA, r7=0x5555, retired_cnt +2, last_pc=wpc1.
- Both slots write r9 (0x1111 slot0, 0x2222 slot1) -> r9=0x2222, collision=1 for exactly one cycle.
- we0=1 to r0 with 0xFFFF, and valid1=0/we1=1 to r4 -> r0 reads 0, r4 unchanged, retired_cnt +1, last_pc=wpc0.
- With RF_BYPASS_EN: write r6=0xBEEF while raddr2=6 -> rdata2=0xBEEF same cycle; without macro: old r6 that cycle, 0xBEEF next.
- retired_cnt preloaded near 2^CNT_W-1 via retirements, dual retire -> wraps to 0 or 1 correctly.
